// File: rtl/door_lock_pkg.sv
// Shared types and coil tables for the door-lock bolt stepper sequencer.
// Build option: DOOR_LOCK_HALF_STEP_EN selects the 8-entry half-step table instead of full-step.
package door_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPEN  = 3'd1,
        ST_HOLD  = 3'd2,
        ST_CLOSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

`ifdef DOOR_LOCK_HALF_STEP_EN
    localparam int PHASE_COUNT = 8;
`else
    localparam int PHASE_COUNT = 4;
`endif

    // Phase counts are powers of two, so the phase register wraps by its width.
    localparam int PHASE_W = $clog2(PHASE_COUNT);

    function automatic logic [3:0] full_step_pattern(input logic [1:0] p);
        logic [3:0] pat;
        case (p)
            2'd0:    pat = 4'b1001;
            2'd1:    pat = 4'b1010;
            2'd2:    pat = 4'b0110;
            default: pat = 4'b0101;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] half_step_pattern(input logic [2:0] p);
        logic [3:0] pat;
        case (p)
            3'd0:    pat = 4'b1000;
            3'd1:    pat = 4'b1010;
            3'd2:    pat = 4'b0010;
            3'd3:    pat = 4'b0110;
            3'd4:    pat = 4'b0100;
            3'd5:    pat = 4'b0101;
            3'd6:    pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
        return pat;
    endfunction

    function automatic logic [3:0] phase_pattern(input logic [PHASE_W-1:0] p);
`ifdef DOOR_LOCK_HALF_STEP_EN
        return half_step_pattern(p);
`else
        return full_step_pattern(p);
`endif
    endfunction

endpackage

// File: rtl/stepper_phase_gen.sv
// Coil phase index register and table lookup; coils are de-energised whenever enable is low.
// The phase index survives across sequences so reverse steps continue from where the bolt stopped.
module stepper_phase_gen
    import door_lock_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       step_fwd,
    input  logic       step_rev,
    input  logic       enable,
    output logic [3:0] motor_out
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] phase_next;

    always_comb begin
        phase_next = phase;
        if (step_fwd) begin
            phase_next = phase + 1'b1;
        end else if (step_rev) begin
            phase_next = phase - 1'b1;
        end
    end

    // Drive the pattern of the phase being entered so the coil output stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= '0;
            motor_out <= 4'b0000;
        end else begin
            phase     <= phase_next;
            motor_out <= enable ? phase_pattern(phase_next) : 4'b0000;
        end
    end

endmodule

// File: rtl/door_lock_stepper_seq.sv
// Door-lock bolt sequencer: open N steps, hold, close, report done until trigger drops.
// Build option: DOOR_LOCK_HALF_STEP_EN (half-step coil table, handled in door_lock_pkg).
module door_lock_stepper_seq
    import door_lock_pkg::*;
#(
    parameter int STEP_W      = 16,
    parameter int SPEED_DELAY = 100000,
    parameter int WAIT_DELAY  = 24000000,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trigger,
    input  logic              abort,
    input  logic [STEP_W-1:0] steps_in,
    output logic [3:0]        motor_out,
    output logic              busy,
    output logic              sequence_done,
    output logic              aborted,
    output logic [STEP_W-1:0] position,
    output state_t            dbg_state
);

    localparam logic [CNT_W-1:0] SPEED_LAST = CNT_W'(SPEED_DELAY - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_DELAY - 1);

    // Handshake: trigger is a level request sampled only in IDLE; sequence_done stays
    // high in DONE until trigger is low, so the requester must drop trigger to re-arm.
    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  clk_cnt;
    logic [STEP_W-1:0] target;
    logic              step_tick;
    logic              step_fwd;
    logic              step_rev;
    logic              abort_take;
    logic              run_next;

    assign step_tick  = (clk_cnt == SPEED_LAST);
    assign step_fwd   = (state == ST_OPEN) && step_tick;
    assign step_rev   = (state == ST_CLOSE) && (position != '0) && step_tick;
    assign abort_take = abort && ((state == ST_OPEN) || (state == ST_HOLD));
    assign run_next   = (state_next == ST_OPEN) || (state_next == ST_HOLD) ||
                        (state_next == ST_CLOSE);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_next = (steps_in != '0) ? ST_OPEN : ST_DONE;
                end
            end
            ST_OPEN: begin
                // An abort on a step edge still lets that step count before reversing.
                if (abort_take) begin
                    state_next = ST_CLOSE;
                end else if (step_fwd && ((position + STEP_W'(1)) == target)) begin
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (abort_take || (clk_cnt == WAIT_LAST)) begin
                    state_next = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                if (position == '0) begin
                    state_next = ST_DONE;
                end else if (step_rev && (position == STEP_W'(1))) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!trigger) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt       <= '0;
            target        <= '0;
            position      <= '0;
            busy          <= 1'b0;
            sequence_done <= 1'b0;
            aborted       <= 1'b0;
        end else begin
            busy          <= run_next;
            sequence_done <= (state_next == ST_DONE);

            if ((state == ST_IDLE) && trigger) begin
                target <= steps_in;
            end

            // One divider serves both the step period and the hold time.
            if (!run_next || (state_next != state) || ((state != ST_HOLD) && step_tick)) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + CNT_W'(1);
            end

            if (step_fwd) begin
                position <= position + STEP_W'(1);
            end else if (step_rev) begin
                position <= position - STEP_W'(1);
            end

            if (abort_take) begin
                aborted <= 1'b1;
            end else if (state_next == ST_IDLE) begin
                aborted <= 1'b0;
            end
        end
    end

    stepper_phase_gen u_phase_gen (
        .clk       (clk),
        .reset     (reset),
        .step_fwd  (step_fwd),
        .step_rev  (step_rev),
        .enable    (run_next),
        .motor_out (motor_out)
    );

endmodule

// File: tb/tb_door_lock_stepper_seq.sv
// Directed bench for door_lock_stepper_seq with SPEED_DELAY=4, WAIT_DELAY=10.
// Honours DOOR_LOCK_HALF_STEP_EN for the expected coil table.
module tb_door_lock_stepper_seq;
    import door_lock_pkg::*;

    localparam int STEP_W = 16;
    localparam int SPEED  = 4;
    localparam int WAIT   = 10;
    localparam int CNT_W  = 32;
    localparam int BUDGET = 200;
`ifdef DOOR_LOCK_HALF_STEP_EN
    localparam int NPH = 8;
`else
    localparam int NPH = 4;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trigger = 1'b0;
    logic              abort = 1'b0;
    logic [STEP_W-1:0] steps_in = '0;
    logic [3:0]        motor_out;
    logic              busy;
    logic              sequence_done;
    logic              aborted;
    logic [STEP_W-1:0] position;
    state_t            dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_phase = 0;
    int prev_pos  = 0;
    int peak      = 0;
    bit busy_seen = 0;
    bit motor_ok  = 1;

    typedef struct {
        int steps;
        int abort_cyc;
        int latency;
        int peak;
        bit was_aborted;
    } vec_t;

    vec_t vecs[10];

    door_lock_stepper_seq #(
        .STEP_W      (STEP_W),
        .SPEED_DELAY (SPEED),
        .WAIT_DELAY  (WAIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .abort         (abort),
        .steps_in      (steps_in),
        .motor_out     (motor_out),
        .busy          (busy),
        .sequence_done (sequence_done),
        .aborted       (aborted),
        .position      (position),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        total_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic [3:0] pattern(input int p);
        logic [3:0] pat;
`ifdef DOOR_LOCK_HALF_STEP_EN
        case (p)
            0: pat = 4'b1000;
            1: pat = 4'b1010;
            2: pat = 4'b0010;
            3: pat = 4'b0110;
            4: pat = 4'b0100;
            5: pat = 4'b0101;
            6: pat = 4'b0001;
            default: pat = 4'b1001;
        endcase
`else
        case (p)
            0: pat = 4'b1001;
            1: pat = 4'b1010;
            2: pat = 4'b0110;
            default: pat = 4'b0101;
        endcase
`endif
        return pat;
    endfunction

    // Follows position moves to predict the coil pattern the DUT must show.
    task automatic observe();
        if (int'(position) == prev_pos + 1) exp_phase = (exp_phase + 1) % NPH;
        else if (int'(position) == prev_pos - 1) exp_phase = (exp_phase + NPH - 1) % NPH;
        else if (int'(position) != prev_pos) motor_ok = 0;
        prev_pos = int'(position);
        if (prev_pos > peak) peak = prev_pos;
        if (busy) busy_seen = 1;
        if (motor_out != (busy ? pattern(exp_phase) : 4'b0000)) motor_ok = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int cyc;
        bit hold_ok;
        cyc = 0;
        hold_ok = 1;
        prev_pos = 0;
        peak = 0;
        busy_seen = 0;
        motor_ok = 1;
        steps_in = STEP_W'(v.steps);
        trigger = 1'b1;
        tick();
        observe();
        while (!sequence_done && cyc < BUDGET) begin
            abort = (cyc == v.abort_cyc);
            tick();
            abort = 1'b0;
            cyc++;
            observe();
        end
        check($sformatf("v%0d latency", idx), cyc, v.latency);
        check($sformatf("v%0d peak_position", idx), peak, v.peak);
        check($sformatf("v%0d aborted", idx), aborted, v.was_aborted);
        check($sformatf("v%0d final_position", idx), position, 0);
        check($sformatf("v%0d busy_seen", idx), busy_seen, v.steps != 0);
        check($sformatf("v%0d motor_walk", idx), motor_ok, 1);
        repeat (20) begin
            tick();
            if (!sequence_done || busy || motor_out != 4'b0000 || aborted != v.was_aborted)
                hold_ok = 0;
        end
        check($sformatf("v%0d done_held", idx), hold_ok, 1);
        trigger = 1'b0;
        tick();
        check($sformatf("v%0d done_cleared", idx), sequence_done, 0);
        check($sformatf("v%0d aborted_cleared", idx), aborted, 0);
        check($sformatf("v%0d back_idle", idx), int'(dbg_state), int'(ST_IDLE));
        tick();
    endtask

    initial begin
        int cyc;
        vecs[0] = '{steps: 8, abort_cyc: -1, latency: 74, peak: 8, was_aborted: 0};
        vecs[1] = '{steps: 0, abort_cyc: -1, latency: 0,  peak: 0, was_aborted: 0};
        vecs[2] = '{steps: 1, abort_cyc: -1, latency: 18, peak: 1, was_aborted: 0};
        vecs[3] = '{steps: 3, abort_cyc: -1, latency: 34, peak: 3, was_aborted: 0};
        vecs[4] = '{steps: 8, abort_cyc: 12, latency: 25, peak: 3, was_aborted: 1};
        vecs[5] = '{steps: 2, abort_cyc: 8,  latency: 17, peak: 2, was_aborted: 1};
        vecs[6] = '{steps: 8, abort_cyc: 3,  latency: 8,  peak: 1, was_aborted: 1};
        vecs[7] = '{steps: 8, abort_cyc: 0,  latency: 2,  peak: 0, was_aborted: 1};
        vecs[8] = '{steps: 1, abort_cyc: 15, latency: 18, peak: 1, was_aborted: 0};
        vecs[9] = '{steps: 5, abort_cyc: -1, latency: 50, peak: 5, was_aborted: 0};

        reset = 1'b1;
        tick();
        tick();
        check("reset motor_out", motor_out, 0);
        check("reset busy", busy, 0);
        check("reset sequence_done", sequence_done, 0);
        check("reset aborted", aborted, 0);
        check("reset position", position, 0);
        check("reset state", int'(dbg_state), int'(ST_IDLE));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Abort while idle must not start anything.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("idle_abort state", int'(dbg_state), int'(ST_IDLE));
        check("idle_abort aborted", aborted, 0);
        check("idle_abort busy", busy, 0);

        // Trigger dropped mid-run: sequence completes, then returns to idle at once.
        steps_in = STEP_W'(2);
        trigger = 1'b1;
        tick();
        cyc = 0;
        tick();
        cyc++;
        trigger = 1'b0;
        while (!sequence_done && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        check("trig_drop latency", cyc, 26);
        tick();
        check("trig_drop idle", int'(dbg_state), int'(ST_IDLE));
        check("trig_drop done_cleared", sequence_done, 0);

        // Reset in the middle of opening.
        steps_in = STEP_W'(8);
        trigger = 1'b1;
        tick();
        repeat (9) tick();
        check("pre_reset position", position, 2);
        reset = 1'b1;
        trigger = 1'b0;
        tick();
        check("mid_reset motor_out", motor_out, 0);
        check("mid_reset busy", busy, 0);
        check("mid_reset position", position, 0);
        check("mid_reset state", int'(dbg_state), int'(ST_IDLE));
        reset = 1'b0;
        exp_phase = 0;
        tick();
        run_vec(10, vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
